// File: rtl/m_ext_issue_ctrl.sv
// Issue slot and fixed-latency destination scoreboard for the M-extension pipeline.
// Optional: define M_EXT_WB_FWD_EN to drop the writeback slot from the hazard window.
module m_ext_issue_ctrl #(
   parameter int WORD_SIZE = 32,
   parameter int REG_SIZE  = 5,
   parameter int M_LATENCY = 5
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [2:0]           req_opcode_i,
   input  logic [REG_SIZE-1:0]  req_rs1_i,
   input  logic [REG_SIZE-1:0]  req_rs2_i,
   input  logic                 req_rs1_use_i,
   input  logic                 req_rs2_use_i,
   input  logic [REG_SIZE-1:0]  req_rd_i,
   input  logic                 req_rf_we_i,
   input  logic [WORD_SIZE-1:0] req_src_a_i,
   input  logic [WORD_SIZE-1:0] req_src_b_i,
   input  logic                 flush_i,
   output logic                 valid_m1_o,
   output logic [2:0]           opcode_o,
   output logic                 rf_we_o,
   output logic [WORD_SIZE-1:0] src_a_o,
   output logic [WORD_SIZE-1:0] src_b_o,
   output logic [REG_SIZE-1:0]  rf_waddr_o,
   input  logic [REG_SIZE-1:0]  hz_rs1_i,
   input  logic [REG_SIZE-1:0]  hz_rs2_i,
   output logic                 hz_stall_o,
   output logic                 m_wb_next_o,
   output logic [2:0]           outstanding_o,
   output logic                 idle_o
);

   typedef struct packed {
      logic                valid;
      logic                we;
      logic [REG_SIZE-1:0] rd;
   } slot_t;

`ifdef M_EXT_WB_FWD_EN
   localparam int HZ_LAST = M_LATENCY - 1;
`else
   localparam int HZ_LAST = M_LATENCY;
`endif

   slot_t                slot_q [M_LATENCY+1];
   logic [2:0]           opcode_q;
   logic [WORD_SIZE-1:0] src_a_q;
   logic [WORD_SIZE-1:0] src_b_q;

   logic       pend_rs1, pend_rs2, pend_hz1, pend_hz2;
   logic       accept;
   logic [2:0] valid_cnt;

   // A slot's we bit already excludes rd == x0, so a match implies a non-zero register.
   always_comb begin
      pend_rs1 = 1'b0;
      pend_rs2 = 1'b0;
      pend_hz1 = 1'b0;
      pend_hz2 = 1'b0;
      for (int i = 0; i <= HZ_LAST; i++) begin
         if (slot_q[i].valid && slot_q[i].we) begin
            if (slot_q[i].rd == req_rs1_i) pend_rs1 = 1'b1;
            if (slot_q[i].rd == req_rs2_i) pend_rs2 = 1'b1;
            if (slot_q[i].rd == hz_rs1_i)  pend_hz1 = 1'b1;
            if (slot_q[i].rd == hz_rs2_i)  pend_hz2 = 1'b1;
         end
      end
   end

   always_comb begin
      valid_cnt = '0;
      for (int i = 0; i <= M_LATENCY; i++) valid_cnt = valid_cnt + 3'(slot_q[i].valid);
   end

   assign req_ready_o = !flush_i
                        && !(req_rs1_use_i && pend_rs1)
                        && !(req_rs2_use_i && pend_rs2);
   assign accept      = req_valid_i && req_ready_o;

   // NOTE: sequential state uses non-blocking assignments so every slot shifts from its
   // pre-edge neighbour; the whole scoreboard is reset because its valid bits gate hazards.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         for (int i = 0; i <= M_LATENCY; i++) slot_q[i] <= '0;
         opcode_q <= '0;
         src_a_q  <= '0;
         src_b_q  <= '0;
      end else begin
         for (int i = 1; i <= M_LATENCY; i++) slot_q[i] <= slot_q[i-1];
         if (accept) begin
            slot_q[0] <= '{valid: 1'b1, we: req_rf_we_i && (req_rd_i != '0), rd: req_rd_i};
            opcode_q  <= req_opcode_i;
            src_a_q   <= req_src_a_i;
            src_b_q   <= req_src_b_i;
         end else begin
            // The destination address holds; only the qualifiers drop.
            slot_q[0].valid <= 1'b0;
            slot_q[0].we    <= 1'b0;
         end
      end
   end

   assign valid_m1_o    = slot_q[0].valid;
   assign rf_we_o       = slot_q[0].we;
   assign rf_waddr_o    = slot_q[0].rd;
   assign opcode_o      = opcode_q;
   assign src_a_o       = src_a_q;
   assign src_b_o       = src_b_q;
   assign hz_stall_o    = pend_hz1 || pend_hz2;
   assign m_wb_next_o   = slot_q[M_LATENCY-1].valid && slot_q[M_LATENCY-1].we;
   assign outstanding_o = valid_cnt;
   assign idle_o        = (valid_cnt == 3'd0);

endmodule

// File: tb/tb_m_ext_issue_ctrl.sv
// Self-checking bench for m_ext_issue_ctrl: directed scenarios plus randomized traffic
// against an age-based in-flight op list.
module tb_m_ext_issue_ctrl;
   localparam int WS = 32;
   localparam int RS = 5;
   localparam int L  = 5;
`ifdef M_EXT_WB_FWD_EN
   localparam int WIN = L - 1;
`else
   localparam int WIN = L;
`endif
   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_DIV = 3'd4;

   logic          clk, rsn;
   logic          req_valid, req_ready, req_rs1_use, req_rs2_use, req_rf_we, flush;
   logic [2:0]    req_opcode, opcode;
   logic [RS-1:0] req_rs1, req_rs2, req_rd, rf_waddr, hz_rs1, hz_rs2;
   logic [WS-1:0] req_src_a, req_src_b, src_a, src_b;
   logic          valid_m1, rf_we, hz_stall, m_wb_next, idle;
   logic [2:0]    outstanding;

   m_ext_issue_ctrl #(.WORD_SIZE(WS), .REG_SIZE(RS), .M_LATENCY(L)) dut (
      .clk_i(clk), .rsn_i(rsn),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_opcode_i(req_opcode),
      .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
      .req_rs1_use_i(req_rs1_use), .req_rs2_use_i(req_rs2_use),
      .req_rd_i(req_rd), .req_rf_we_i(req_rf_we),
      .req_src_a_i(req_src_a), .req_src_b_i(req_src_b), .flush_i(flush),
      .valid_m1_o(valid_m1), .opcode_o(opcode), .rf_we_o(rf_we),
      .src_a_o(src_a), .src_b_o(src_b), .rf_waddr_o(rf_waddr),
      .hz_rs1_i(hz_rs1), .hz_rs2_i(hz_rs2), .hz_stall_o(hz_stall),
      .m_wb_next_o(m_wb_next), .outstanding_o(outstanding), .idle_o(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: every in-flight op with its age in cycles since it entered the issue slot.
   typedef struct {
      int rd;
      bit tw;
      int age;
   } rec_t;
   rec_t          mq[$];
   logic [2:0]    m_op;
   logic [WS-1:0] m_a, m_b;
   logic [RS-1:0] m_rd;

   function automatic bit m_pend(input logic [RS-1:0] r);
      foreach (mq[k])
         if (r != 0 && mq[k].tw && mq[k].rd == int'(r) && mq[k].age <= WIN) return 1'b1;
      return 1'b0;
   endfunction

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req_valid = 0; req_opcode = 0; req_rs1 = 0; req_rs2 = 0;
      req_rs1_use = 0; req_rs2_use = 0; req_rd = 0; req_rf_we = 0;
      req_src_a = 0; req_src_b = 0; flush = 0; hz_rs1 = 0; hz_rs2 = 0;
   endtask

   task automatic set_req(input logic [2:0] op, input logic [RS-1:0] rd,
                          input logic [RS-1:0] rs1, input logic [RS-1:0] rs2);
      req_valid = 1; req_opcode = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
      req_rs1_use = 1; req_rs2_use = 1; req_rf_we = 1;
      req_src_a = $urandom; req_src_b = $urandom;
   endtask

   task automatic apply_reset;
      idle_inputs();
      @(negedge clk); rsn = 0;
      @(negedge clk); rsn = 1;
      mq.delete(); m_op = 0; m_a = 0; m_b = 0; m_rd = 0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rsn = 1;
      #2 rsn = 0;
      #1;
      n_vec++; if (valid_m1 !== 1'b0) begin n_err++; $display("FAIL reset_valid_m1 got=%b exp=0", valid_m1); end
      n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
      n_vec++; if ({opcode, src_a, src_b, rf_waddr} !== '0) begin n_err++;
         $display("FAIL reset_data got=%h/%h/%h/%h exp=0", opcode, src_a, src_b, rf_waddr); end
      n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
      n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b exp=1", idle); end
      n_vec++; if (m_wb_next !== 1'b0) begin n_err++; $display("FAIL reset_wb_next got=%b exp=0", m_wb_next); end
      @(negedge clk); rsn = 1;
      mq.delete(); m_op = 0; m_a = 0; m_b = 0; m_rd = 0;
   endtask

   task automatic test_back_to_back;
      logic [WS-1:0] a0, b0;
      apply_reset();
      next_cycle();                                   // cycle 0
      set_req(OP_MUL, 5'd3, 5'd1, 5'd2); a0 = req_src_a; b0 = req_src_b; #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0 got=%b exp=1", req_ready); end
      next_cycle();                                   // cycle 1
      n_vec++; if ({valid_m1, rf_waddr, outstanding} !== {1'b1, 5'd3, 3'd1}) begin n_err++;
         $display("FAIL b2b_cycle1 got=%b/%0d/%0d exp=1/3/1", valid_m1, rf_waddr, outstanding); end
      n_vec++; if ({opcode, src_a, src_b} !== {OP_MUL, a0, b0}) begin n_err++;
         $display("FAIL b2b_data1 got=%h/%h/%h exp=%h/%h/%h", opcode, src_a, src_b, OP_MUL, a0, b0); end
      set_req(OP_MUL, 5'd4, 5'd1, 5'd2); #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1 got=%b exp=1", req_ready); end
      next_cycle();                                   // cycle 2
      req_valid = 0; #1;
      n_vec++; if ({valid_m1, rf_waddr, outstanding} !== {1'b1, 5'd4, 3'd2}) begin n_err++;
         $display("FAIL b2b_cycle2 got=%b/%0d/%0d exp=1/4/2", valid_m1, rf_waddr, outstanding); end
      next_cycle();                                   // cycle 3
      n_vec++; if ({valid_m1, outstanding} !== {1'b0, 3'd2}) begin n_err++;
         $display("FAIL b2b_cycle3 got=%b/%0d exp=0/2", valid_m1, outstanding); end
   endtask

   task automatic test_raw_stall;
      int first;
      apply_reset();
      next_cycle();                                   // cycle 0
      set_req(OP_MUL, 5'd5, 5'd1, 5'd2); #1;
      next_cycle();                                   // cycle 1
      set_req(OP_DIV, 5'd6, 5'd5, 5'd0); req_rs2_use = 0;
      first = -1;
      for (int c = 1; c <= 12 && first < 0; c++) begin
         #1;
         if (req_ready === 1'b1) first = c;
         else next_cycle();
      end
      n_vec++; if (first != WIN + 2) begin n_err++;
         $display("FAIL raw_first_ready got=%0d exp=%0d", first, WIN + 2); end
      next_cycle();
      req_valid = 0; #1;
      n_vec++; if ({valid_m1, opcode, rf_waddr} !== {1'b1, OP_DIV, 5'd6}) begin n_err++;
         $display("FAIL raw_issue got=%b/%0d/%0d exp=1/4/6", valid_m1, opcode, rf_waddr); end
   endtask

   task automatic test_x0;
      apply_reset();
      next_cycle();                                   // cycle 0
      set_req(OP_MUL, 5'd0, 5'd1, 5'd2); #1;
      next_cycle();                                   // cycle 1
      n_vec++; if ({valid_m1, rf_we} !== 2'b10) begin n_err++;
         $display("FAIL x0_issue got=%b%b exp=10", valid_m1, rf_we); end
      set_req(OP_MUL, 5'd7, 5'd0, 5'd0); hz_rs1 = 0; hz_rs2 = 0; #1;
      n_vec++; if ({req_ready, hz_stall} !== 2'b10) begin n_err++;
         $display("FAIL x0_no_stall got=%b%b exp=10", req_ready, hz_stall); end
      next_cycle();                                   // cycle 2
      req_valid = 0; #1;
      n_vec++; if (hz_stall !== 1'b0) begin n_err++; $display("FAIL x0_query got=%b exp=0", hz_stall); end
   endtask

   task automatic test_hz_query;
      logic e_hz, e_wb;
      apply_reset();
      next_cycle();                                   // cycle 0
      set_req(OP_MUL, 5'd9, 5'd1, 5'd2); hz_rs2 = 5'd9; #1;
      n_vec++; if (hz_stall !== 1'b0) begin n_err++; $display("FAIL hz_c0 got=%b exp=0", hz_stall); end
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         req_valid = 0; #1;
         e_hz = (c <= WIN + 1);
         e_wb = (c == L);
         n_vec++; if ({hz_stall, m_wb_next} !== {e_hz, e_wb}) begin n_err++;
            $display("FAIL hz_c%0d got=%b%b exp=%b%b", c, hz_stall, m_wb_next, e_hz, e_wb); end
      end
   endtask

   task automatic test_async_reset;
      apply_reset();
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         set_req(OP_MUL, 5'(10 + c), 5'd1, 5'd2);
      end
      next_cycle();                                   // cycle 3
      req_valid = 0; #1;
      n_vec++; if ({valid_m1, outstanding} !== {1'b1, 3'd3}) begin n_err++;
         $display("FAIL arst_before got=%b/%0d exp=1/3", valid_m1, outstanding); end
      rsn = 0; #1;                                    // mid-cycle, no edge
      n_vec++; if ({valid_m1, outstanding, idle} !== {1'b0, 3'd0, 1'b1}) begin n_err++;
         $display("FAIL arst_after got=%b/%0d/%b exp=0/0/1", valid_m1, outstanding, idle); end
      @(negedge clk); rsn = 1;
      mq.delete(); m_op = 0; m_a = 0; m_b = 0; m_rd = 0;
   endtask

   task automatic test_flush;
      apply_reset();
      next_cycle();                                   // cycle 0
      set_req(OP_MULH, 5'd13, 5'd1, 5'd2); flush = 1; #1;
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%b exp=0", req_ready); end
      next_cycle();                                   // cycle 1
      flush = 0; #1;
      n_vec++; if ({valid_m1, outstanding, req_ready} !== {1'b0, 3'd0, 1'b1}) begin n_err++;
         $display("FAIL flush_c1 got=%b/%0d/%b exp=0/0/1", valid_m1, outstanding, req_ready); end
      next_cycle();                                   // cycle 2
      req_valid = 0; #1;
      n_vec++; if ({valid_m1, rf_waddr, opcode} !== {1'b1, 5'd13, OP_MULH}) begin n_err++;
         $display("FAIL flush_c2 got=%b/%0d/%0d exp=1/13/1", valid_m1, rf_waddr, opcode); end
   endtask

   task automatic test_random(input int n);
      logic          e_rdy, e_hz, e_vm1, e_we, e_wb;
      logic [13:0]   e_ctl, a_ctl;
      int            cnt;
      apply_reset();
      for (int c = 0; c < n; c++) begin
         next_cycle();
         req_valid   = ($urandom_range(3) != 0);
         req_opcode  = 3'($urandom_range(7));
         req_rs1     = 5'($urandom_range(7));
         req_rs2     = 5'($urandom_range(7));
         req_rd      = 5'($urandom_range(7));
         req_rs1_use = 1'($urandom_range(1));
         req_rs2_use = 1'($urandom_range(1));
         req_rf_we   = ($urandom_range(3) != 0);
         req_src_a   = $urandom;
         req_src_b   = $urandom;
         flush       = ($urandom_range(7) == 0);
         hz_rs1      = 5'($urandom_range(7));
         hz_rs2      = 5'($urandom_range(7));
         #1;
         e_rdy = !flush && !(req_rs1_use && m_pend(req_rs1)) && !(req_rs2_use && m_pend(req_rs2));
         e_hz  = m_pend(hz_rs1) || m_pend(hz_rs2);
         e_vm1 = 0; e_we = 0; e_wb = 0;
         foreach (mq[k]) begin
            if (mq[k].age == 0) begin e_vm1 = 1; e_we = mq[k].tw; end
            if (mq[k].age == L - 1 && mq[k].tw) e_wb = 1;
         end
         cnt   = mq.size();
         e_ctl = {e_rdy, e_hz, e_wb, 3'(cnt), cnt == 0, e_vm1, e_we, m_rd};
         a_ctl = {req_ready, hz_stall, m_wb_next, outstanding, idle, valid_m1, rf_we, rf_waddr};
         n_vec++; if (a_ctl !== e_ctl) begin n_err++;
            $display("FAIL rand_ctl c=%0d got=%b exp=%b (rdy,hz,wb,out,idle,vm1,we,waddr)", c, a_ctl, e_ctl); end
         n_vec++; if ({opcode, src_a, src_b} !== {m_op, m_a, m_b}) begin n_err++;
            $display("FAIL rand_data c=%0d got=%h/%h/%h exp=%h/%h/%h", c, opcode, src_a, src_b, m_op, m_a, m_b); end
         // Advance the model across the coming edge.
         foreach (mq[k]) mq[k].age = mq[k].age + 1;
         while (mq.size() > 0 && mq[0].age > L) void'(mq.pop_front());
         if (req_valid && e_rdy) begin
            mq.push_back('{rd: int'(req_rd), tw: (req_rf_we && req_rd != 0), age: 0});
            m_op = req_opcode; m_a = req_src_a; m_b = req_src_b; m_rd = req_rd;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_raw_stall();
      test_x0();
      test_hz_query();
      test_async_reset();
      test_flush();
      test_random(600);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
